// File: rtl/v850_pkg.sv
// Shared constants for the V850 decode stage: circuit selects,
// opcode and sub-opcode encodings, FSM states and operand kinds.
package v850_pkg;

    localparam logic [4:0] SEL_SUB = 5'b00000;
    localparam logic [4:0] SEL_ADD = 5'b00001;
    localparam logic [4:0] SEL_AND = 5'b00010;
    localparam logic [4:0] SEL_OR  = 5'b00011;
    localparam logic [4:0] SEL_BSH = 5'b00110;
    localparam logic [4:0] SEL_BSW = 5'b00111;
    localparam logic [4:0] SEL_DIV = 5'b01000;
    localparam logic [4:0] SEL_HSW = 5'b10000;
    localparam logic [4:0] SEL_NOP = 5'b11111;

    localparam logic [5:0] OP_OR    = 6'b001000;
    localparam logic [5:0] OP_AND   = 6'b001010;
    localparam logic [5:0] OP_SUB   = 6'b001101;
    localparam logic [5:0] OP_ADD   = 6'b001110;
    localparam logic [5:0] OP_CMP   = 6'b001111;
    localparam logic [5:0] OP_ADDI5 = 6'b010010;
    localparam logic [5:0] OP_CMPI5 = 6'b010011;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ORI   = 6'b110100;
    localparam logic [5:0] OP_ANDI  = 6'b110110;
    localparam logic [5:0] OP_EXT   = 6'b111111;

    localparam logic [10:0] SUB_DIV = 11'h2C0;
    localparam logic [10:0] SUB_BSW = 11'h340;
    localparam logic [10:0] SUB_BSH = 11'h342;
    localparam logic [10:0] SUB_HSW = 11'h344;

    typedef enum logic [1:0] {
        S_HW0,
        S_HW1,
        S_ISSUE
    } state_t;

    typedef enum logic [3:0] {
        OPK_RR,
        OPK_RR_NEG,
        OPK_IMM5,
        OPK_IMM5_NEG,
        OPK_IMM16_S,
        OPK_IMM16_Z,
        OPK_BSW,
        OPK_BSH,
        OPK_HSW
    } opk_t;

    function automatic logic is_long(input logic [5:0] op);
        return op inside {OP_ADDI, OP_ORI, OP_ANDI, OP_EXT};
    endfunction

endpackage

// File: rtl/v850_operand_former.sv
// Combinational operand shaping: immediate extension, two's-complement
// negation for SUB/CMP, and byte/halfword swaps for BSW/BSH/HSW.
module v850_operand_former
    import v850_pkg::*;
(
    input  opk_t        i_kind,
    input  logic [31:0] i_gr_r1,
    input  logic [31:0] i_gr_r2,
    input  logic [4:0]  i_imm5,
    input  logic [15:0] i_imm16,
    output logic [31:0] o_op1,
    output logic [31:0] o_op2
);

    logic [31:0] w_sext5;
    logic [31:0] w_sext16;

    assign w_sext5  = {{27{i_imm5[4]}}, i_imm5};
    assign w_sext16 = {{16{i_imm16[15]}}, i_imm16};

    always_comb begin
        o_op1 = i_gr_r1;
        o_op2 = i_gr_r2;
        case (i_kind)
            OPK_RR_NEG:   o_op1 = 32'd0 - i_gr_r1;
            OPK_IMM5:     o_op1 = w_sext5;
            OPK_IMM5_NEG: o_op1 = 32'd0 - w_sext5;
            OPK_IMM16_S: begin
                o_op1 = w_sext16;
                o_op2 = i_gr_r1;
            end
            OPK_IMM16_Z: begin
                o_op1 = {16'h0000, i_imm16};
                o_op2 = i_gr_r1;
            end
            OPK_BSW: begin
                o_op1 = '0;
                o_op2 = {i_gr_r2[7:0], i_gr_r2[15:8],
                         i_gr_r2[23:16], i_gr_r2[31:24]};
            end
            OPK_BSH: begin
                o_op1 = '0;
                o_op2 = {i_gr_r2[23:16], i_gr_r2[31:24],
                         i_gr_r2[7:0], i_gr_r2[15:8]};
            end
            OPK_HSW: begin
                o_op1 = '0;
                o_op2 = {i_gr_r2[15:0], i_gr_r2[31:16]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instruction_decoder.sv
// V850 decode stage: assembles halfwords, decodes, reads GR operands
// and fills a one-entry issue slot with a RAW interlock.
module instruction_decoder
    import v850_pkg::*;
#(
    parameter logic [4:0] NOP_SEL = SEL_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [15:0] hw_i,
    input  logic        hw_valid_i,
    output logic        hw_ready_o,
    input  logic [31:0] gr_i [32],
    input  logic        ready_i,
    output logic        valid_o,
    output logic [4:0]  destination_o,
    output logic [31:0] reg1_o,
    output logic [31:0] reg2_o,
    output logic [31:0] reg3_o,
    output logic        increment_bit_o,
    output logic [4:0]  circuit_sel_o,
    output logic        illegal_o
);

    state_t      r_state, w_state_nx;
    logic [15:0] r_hw0, r_hw1;
    logic        r_valid, r_illegal;
    logic [4:0]  r_sel, r_dest, r_reg3;
    logic [31:0] r_reg1, r_reg2;

    logic        w_cand;
    logic [15:0] w_hw0, w_hw1;
    logic [5:0]  w_op;
    logic [4:0]  w_r1, w_r2;
    logic        w_legal, w_use1, w_use2;
    logic [4:0]  w_sel, w_dest, w_reg3;
    opk_t        w_kind;
    logic [31:0] w_op1, w_op2;
    logic        w_hz, w_free, w_load, w_ill;

    // A 16-bit op, or the second halfword, is decoded as it arrives so
    // an unblocked instruction reaches the slot on its accept edge;
    // S_ISSUE only holds an instruction the slot could not take.
    always_comb begin
        w_cand = 1'b0;
        w_hw0  = r_hw0;
        w_hw1  = r_hw1;
        case (r_state)
            S_HW0: begin
                w_hw0  = hw_i;
                w_hw1  = '0;
                w_cand = hw_valid_i && !is_long(hw_i[10:5]);
            end
            S_HW1: begin
                w_hw1  = hw_i;
                w_cand = hw_valid_i;
            end
            S_ISSUE: w_cand = 1'b1;
            default: ;
        endcase
    end

    assign w_op = w_hw0[10:5];
    assign w_r1 = w_hw0[4:0];
    assign w_r2 = w_hw0[15:11];

    always_comb begin
        w_legal = 1'b1;
        w_use1  = 1'b0;
        w_use2  = 1'b0;
        w_sel   = SEL_ADD;
        w_kind  = OPK_RR;
        w_dest  = w_r2;
        w_reg3  = '0;
        case (w_op)
            OP_ADD: begin
                w_use1 = 1'b1;
                w_use2 = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                w_use1 = 1'b1;
                w_use2 = 1'b1;
                w_sel  = SEL_SUB;
                w_kind = OPK_RR_NEG;
                if (w_op == OP_CMP) w_dest = '0;
            end
            OP_AND, OP_OR: begin
                w_use1 = 1'b1;
                w_use2 = 1'b1;
                w_sel  = (w_op == OP_AND) ? SEL_AND : SEL_OR;
            end
            OP_ADDI5: begin
                w_use2 = 1'b1;
                w_kind = OPK_IMM5;
            end
            OP_CMPI5: begin
                w_use2 = 1'b1;
                w_sel  = SEL_SUB;
                w_kind = OPK_IMM5_NEG;
                w_dest = '0;
            end
            OP_ADDI: begin
                w_use1 = 1'b1;
                w_kind = OPK_IMM16_S;
            end
            OP_ANDI, OP_ORI: begin
                w_use1 = 1'b1;
                w_kind = OPK_IMM16_Z;
                w_sel  = (w_op == OP_ANDI) ? SEL_AND : SEL_OR;
            end
            OP_EXT: begin
                w_use2 = 1'b1;
                w_dest = w_hw1[15:11];
                case (w_hw1[10:0])
                    SUB_DIV: begin
                        w_use1 = 1'b1;
                        w_sel  = SEL_DIV;
                        w_dest = w_r2;
                        w_reg3 = w_hw1[15:11];
                    end
                    SUB_BSW: begin
                        w_sel  = SEL_BSW;
                        w_kind = OPK_BSW;
                    end
                    SUB_BSH: begin
                        w_sel  = SEL_BSH;
                        w_kind = OPK_BSH;
                    end
                    SUB_HSW: begin
                        w_sel  = SEL_HSW;
                        w_kind = OPK_HSW;
                    end
                    default: begin
                        w_legal = 1'b0;
                        w_use2  = 1'b0;
                    end
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    v850_operand_former u_former (
        .i_kind  (w_kind),
        .i_gr_r1 (gr_i[w_r1]),
        .i_gr_r2 (gr_i[w_r2]),
        .i_imm5  (w_r1),
        .i_imm16 (w_hw1),
        .o_op1   (w_op1),
        .o_op2   (w_op2)
    );

    // r0 is hardwired zero, so it never creates a dependency.
    assign w_hz = r_valid &&
        ((w_use1 && w_r1 != 5'd0 &&
          (w_r1 == r_dest || w_r1 == r_reg3)) ||
         (w_use2 && w_r2 != 5'd0 &&
          (w_r2 == r_dest || w_r2 == r_reg3)));

    assign w_free = !r_valid || ready_i;
    assign w_load = w_cand && w_legal && !w_hz && w_free && !flush_i;
    assign w_ill  = w_cand && !w_legal && w_free && !flush_i;

    always_comb begin
        w_state_nx = r_state;
        if (flush_i) begin
            w_state_nx = S_HW0;
        end else begin
            case (r_state)
                S_HW0: if (hw_valid_i) begin
                    if (is_long(hw_i[10:5])) w_state_nx = S_HW1;
                    else if (!(w_load || w_ill)) w_state_nx = S_ISSUE;
                end
                S_HW1: if (hw_valid_i) begin
                    w_state_nx = (w_load || w_ill) ? S_HW0 : S_ISSUE;
                end
                S_ISSUE: if (w_load || w_ill) w_state_nx = S_HW0;
                default: w_state_nx = S_HW0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_HW0;
            r_hw0     <= '0;
            r_hw1     <= '0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            r_sel     <= NOP_SEL;
            r_dest    <= '0;
            r_reg3    <= '0;
            r_reg1    <= '0;
            r_reg2    <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_illegal <= w_ill;
            if (!flush_i && hw_valid_i && r_state == S_HW0) r_hw0 <= hw_i;
            if (!flush_i && hw_valid_i && r_state == S_HW1) r_hw1 <= hw_i;
            if (flush_i) begin
                r_valid <= 1'b0;
                r_sel   <= NOP_SEL;
            end else if (w_load) begin
                r_valid <= 1'b1;
                r_sel   <= w_sel;
                r_dest  <= w_dest;
                r_reg3  <= w_reg3;
                r_reg1  <= w_op1;
                r_reg2  <= w_op2;
            end else if (ready_i) begin
                r_valid <= 1'b0;
                r_sel   <= NOP_SEL;
            end
        end
    end

    assign hw_ready_o      = (r_state != S_ISSUE);
    assign valid_o         = r_valid;
    assign destination_o   = r_dest;
    assign reg1_o          = r_reg1;
    assign reg2_o          = r_reg2;
    assign reg3_o          = {27'd0, r_reg3};
    assign increment_bit_o = 1'b0;
    assign circuit_sel_o   = r_sel;
    assign illegal_o       = r_illegal;

endmodule

// File: tb/tb_instruction_decoder.sv
// Scoreboard bench for instruction_decoder: directed halfword streams,
// expected slot contents and issue cycle checked by a monitor.
module tb_instruction_decoder;

    typedef struct {
        string       name;
        logic [4:0]  dest;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] r3;
        logic [4:0]  sel;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic [15:0] hw_i;
    logic        hw_valid_i;
    logic        hw_ready_o;
    logic [31:0] gr [32];
    logic        ready_i;
    logic        valid_o;
    logic [4:0]  destination_o;
    logic [31:0] reg1_o, reg2_o, reg3_o;
    logic        increment_bit_o;
    logic [4:0]  circuit_sel_o;
    logic        illegal_o;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   ill_q[$];

    instruction_decoder dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush_i),
        .hw_i            (hw_i),
        .hw_valid_i      (hw_valid_i),
        .hw_ready_o      (hw_ready_o),
        .gr_i            (gr),
        .ready_i         (ready_i),
        .valid_o         (valid_o),
        .destination_o   (destination_o),
        .reg1_o          (reg1_o),
        .reg2_o          (reg2_o),
        .reg3_o          (reg3_o),
        .increment_bit_o (increment_bit_o),
        .circuit_sel_o   (circuit_sel_o),
        .illegal_o       (illegal_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(string n, logic [4:0] d, logic [31:0] a,
                                logic [31:0] b, logic [31:0] c,
                                logic [4:0] s, int t);
        exp_t e;
        e.name = n; e.dest = d; e.r1 = a; e.r2 = b;
        e.r3 = c; e.sel = s; e.cyc = t;
        return e;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, req);
        end
    endtask

    // Monitor: every consumed slot and every illegal pulse is checked.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_o && ready_i) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_issue: cyc %0d sel %h dest %0d",
                             cyc, circuit_sel_o, destination_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (cyc != e.cyc || destination_o !== e.dest ||
                        reg1_o !== e.r1 || reg2_o !== e.r2 ||
                        reg3_o !== e.r3 || circuit_sel_o !== e.sel ||
                        increment_bit_o !== 1'b0) begin
                        fails++;
                        $display({"FAIL %s: got cyc %0d d %0d r1 %h r2 %h r3 %h ",
                                  "sel %b / expected cyc %0d d %0d r1 %h r2 %h ",
                                  "r3 %h sel %b"}, e.name, cyc, destination_o,
                                 reg1_o, reg2_o, reg3_o, circuit_sel_o, e.cyc,
                                 e.dest, e.r1, e.r2, e.r3, e.sel);
                    end
                end
            end
            if (illegal_o) begin
                tests++;
                if (ill_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_illegal: cyc %0d", cyc);
                end else begin
                    int t;
                    t = ill_q.pop_front();
                    if (t != cyc || valid_o) begin
                        fails++;
                        $display("FAIL illegal_pulse: cyc %0d valid %b expected cyc %0d valid 0",
                                 cyc, valid_o, t);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_hw(input logic [15:0] h);
        int n;
        n = 0;
        hw_i = h;
        hw_valid_i = 1'b1;
        while (!hw_ready_o && n < 20) begin
            tick();
            n++;
        end
        if (!hw_ready_o) begin
            tests++;
            fails++;
            $display("FAIL hw_ready_timeout: got 0 expected 1");
        end
        tick();
        hw_valid_i = 1'b0;
    endtask

    task automatic run16(input logic [15:0] h, input exp_t e);
        issue_hw(h);
        e.cyc = cyc;
        exp_q.push_back(e);
        tick();
    endtask

    task automatic run32(input logic [15:0] h0, input logic [15:0] h1,
                         input exp_t e);
        issue_hw(h0);
        issue_hw(h1);
        e.cyc = cyc;
        exp_q.push_back(e);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        hw_i = '0;
        hw_valid_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 32; i++) gr[i] = 32'h0;
        tick();
        tick();
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_sel", {27'd0, circuit_sel_o}, 32'h1F);
        chk("rst_reg1", reg1_o, 32'd0);
        chk("rst_dest", {27'd0, destination_o}, 32'd0);
        chk("rst_ready", {31'd0, hw_ready_o}, 32'd1);
        rst = 1'b0;
        tick();

        gr[1] = 32'd5; gr[2] = 32'd7; gr[3] = 32'd9; gr[5] = 32'h8000_0000;
        run16(16'h11C1, mk("add", 2, 5, 7, 0, 5'b00001, 0));
        run16(16'h11A1, mk("sub", 2, 32'hFFFF_FFFB, 7, 0, 5'b00000, 0));
        run16(16'h11E1, mk("cmp", 0, 32'hFFFF_FFFB, 7, 0, 5'b00000, 0));
        run16(16'h1141, mk("and", 2, 5, 7, 0, 5'b00010, 0));
        run16(16'h1101, mk("or", 2, 5, 7, 0, 5'b00011, 0));
        run16(16'h125D, mk("add_imm5", 2, 32'hFFFF_FFFD, 7, 0, 5'b00001, 0));
        run16(16'h1270, mk("cmp_imm5", 0, 32'h10, 7, 0, 5'b00000, 0));
        run16(16'h11A5, mk("sub_min", 2, 32'h8000_0000, 7, 0, 5'b00000, 0));
        run32(16'h2603, 16'hFFFF, mk("addi", 4, 32'hFFFF_FFFF, 9, 0, 5'b00001, 0));
        run32(16'h26C3, 16'h8001, mk("andi", 4, 32'h8001, 9, 0, 5'b00010, 0));
        run32(16'h2683, 16'hF0F0, mk("ori", 4, 32'hF0F0, 9, 0, 5'b00011, 0));

        gr[2] = 32'h1122_3344;
        run32(16'h17E0, 16'h1B40, mk("bsw", 3, 0, 32'h4433_2211, 0, 5'b00111, 0));
        run32(16'h17E0, 16'h1B42, mk("bsh", 3, 0, 32'h2211_4433, 0, 5'b00110, 0));
        run32(16'h17E0, 16'h1B44, mk("hsw", 3, 0, 32'h3344_1122, 0, 5'b10000, 0));
        gr[1] = 32'd100; gr[2] = 32'd7;
        run32(16'h17E1, 16'h32C0, mk("div", 2, 100, 7, 6, 5'b01000, 0));

        // RAW on the slot destination: one bubble, fresh GR2 read.
        gr[1] = 32'd5; gr[4] = 32'd100;
        issue_hw(16'h11C1);
        exp_q.push_back(mk("b2b_first", 2, 5, 7, 0, 5'b00001, cyc));
        issue_hw(16'h21C2);
        gr[2] = 32'd12;
        exp_q.push_back(mk("b2b_second", 4, 12, 100, 0, 5'b00001, cyc + 1));
        tick(); tick();

        // RAW on the DIV remainder register.
        gr[2] = 32'd7; gr[6] = 32'd33; gr[7] = 32'd44;
        issue_hw(16'h17E1);
        issue_hw(16'h32C0);
        exp_q.push_back(mk("div_first", 2, 5, 7, 6, 5'b01000, cyc));
        issue_hw(16'h39C6);
        gr[6] = 32'd34;
        exp_q.push_back(mk("div_raw", 7, 34, 44, 0, 5'b00001, cyc + 1));
        tick(); tick();

        // CMP writes r0; a following r0 reader must not stall.
        issue_hw(16'h11E1);
        exp_q.push_back(mk("cmp_r0", 0, 32'hFFFF_FFFB, 7, 0, 5'b00000, cyc));
        issue_hw(16'h19C0);
        exp_q.push_back(mk("r0_nohaz", 3, 0, 9, 0, 5'b00001, cyc));
        tick();

        // Slot held while the Executer stalls.
        ready_i = 1'b0;
        issue_hw(16'h11C1);
        tick(); tick(); tick();
        exp_q.push_back(mk("held", 2, 5, 7, 0, 5'b00001, cyc));
        ready_i = 1'b1;
        tick();

        issue_hw(16'h07E0);
        issue_hw(16'h0000);
        ill_q.push_back(cyc);
        tick();
        issue_hw(16'h0000);
        ill_q.push_back(cyc);
        tick();

        // Flush in S_HW1 with a halfword offered; then a clean decode.
        issue_hw(16'h2603);
        hw_i = 16'hFFFF;
        hw_valid_i = 1'b1;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        hw_valid_i = 1'b0;
        run16(16'h11C1, mk("after_flush", 2, 5, 7, 0, 5'b00001, 0));
        hw_i = 16'h11C1;
        hw_valid_i = 1'b1;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        hw_valid_i = 1'b0;
        tick();

        // Reset mid-instruction clears the slot and the partial hw0.
        issue_hw(16'h11A1);
        exp_q.push_back(mk("pre_rst", 2, 32'hFFFF_FFFB, 7, 0, 5'b00000, cyc));
        issue_hw(16'h2603);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", {31'd0, valid_o}, 32'd0);
        chk("mid_rst_reg1", reg1_o, 32'd0);
        chk("mid_rst_sel", {27'd0, circuit_sel_o}, 32'h1F);
        rst = 1'b0;
        tick();
        run16(16'h11C1, mk("after_rst", 2, 5, 7, 0, 5'b00001, 0));

        repeat (4) tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("illegal_q_empty", ill_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
